// File: rtl/riscv_biu_pkg.sv
// Shared types for the two-master BIU arbiter: master identifiers and the
// grouped ownership/arbitration state register.
package riscv_biu_pkg;

  typedef logic biu_mst_t;

  localparam biu_mst_t MST_IMEM = 1'b0;
  localparam biu_mst_t MST_DMEM = 1'b1;

  // gnt: last selected master, prio: tie winner, pend: strobe waiting for
  // stb_ack, aowner: owner of the address phase, downer: owner of the data phase.
  typedef struct packed {
    biu_mst_t gnt;
    biu_mst_t prio;
    logic     pend;
    biu_mst_t aowner;
    biu_mst_t downer;
  } biu_arb_state_t;

  localparam biu_arb_state_t ARB_STATE_RST = '{
    gnt:    MST_IMEM,
    prio:   MST_DMEM,
    pend:   1'b0,
    aowner: MST_IMEM,
    downer: MST_IMEM
  };

  function automatic biu_mst_t other_mst(input biu_mst_t m);
    return ~m;
  endfunction

endpackage

// File: rtl/riscv_biu_rr_arb.sv
// Two-way round-robin selector; hold keeps the current grant so a strobe
// already presented downstream is never withdrawn.
module riscv_biu_rr_arb
  import riscv_biu_pkg::*;
(
  input  logic [1:0] req_i,
  input  biu_mst_t   prio_i,
  input  logic       hold_i,
  input  biu_mst_t   gnt_i,
  output biu_mst_t   sel_o
);

  always_comb begin
    sel_o = gnt_i;
    if (hold_i) begin
      sel_o = gnt_i;
    end else if (&req_i) begin
      sel_o = prio_i;
    end else if (req_i[0]) begin
      sel_o = MST_IMEM;
    end else if (req_i[1]) begin
      sel_o = MST_DMEM;
    end
  end

endmodule

// File: rtl/riscv_biu_arbiter.sv
// Merges the instruction (m0) and data (m1) BIU ports onto one BIU port and
// routes strobe/data/transfer acknowledges back to the owning master.
module riscv_biu_arbiter
  import riscv_biu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic            HCLK,
  input  logic            HRESET,

  input  logic            m0_biu_stb_i,
  output logic            m0_biu_stb_ack_o,
  output logic            m0_biu_d_ack_o,
  input  logic [PLEN-1:0] m0_biu_adri_i,
  output logic [PLEN-1:0] m0_biu_adro_o,
  input  logic [2:0]      m0_biu_size_i,
  input  logic [2:0]      m0_biu_type_i,
  input  logic [2:0]      m0_biu_prot_i,
  input  logic            m0_biu_lock_i,
  input  logic            m0_biu_we_i,
  input  logic [XLEN-1:0] m0_biu_d_i,
  output logic [XLEN-1:0] m0_biu_q_o,
  output logic            m0_biu_ack_o,
  output logic            m0_biu_err_o,

  input  logic            m1_biu_stb_i,
  output logic            m1_biu_stb_ack_o,
  output logic            m1_biu_d_ack_o,
  input  logic [PLEN-1:0] m1_biu_adri_i,
  output logic [PLEN-1:0] m1_biu_adro_o,
  input  logic [2:0]      m1_biu_size_i,
  input  logic [2:0]      m1_biu_type_i,
  input  logic [2:0]      m1_biu_prot_i,
  input  logic            m1_biu_lock_i,
  input  logic            m1_biu_we_i,
  input  logic [XLEN-1:0] m1_biu_d_i,
  output logic [XLEN-1:0] m1_biu_q_o,
  output logic            m1_biu_ack_o,
  output logic            m1_biu_err_o,

  output logic            s_biu_stb_o,
  input  logic            s_biu_stb_ack_i,
  input  logic            s_biu_d_ack_i,
  output logic [PLEN-1:0] s_biu_adri_o,
  input  logic [PLEN-1:0] s_biu_adro_i,
  output logic [2:0]      s_biu_size_o,
  output logic [2:0]      s_biu_type_o,
  output logic [2:0]      s_biu_prot_o,
  output logic            s_biu_lock_o,
  output logic            s_biu_we_o,
  output logic [XLEN-1:0] s_biu_d_o,
  input  logic [XLEN-1:0] s_biu_q_i,
  input  logic            s_biu_ack_i,
  input  logic            s_biu_err_i
);

  biu_arb_state_t st_q, st_d;
  biu_mst_t       sel;
  logic           hold;
  logic           s_stb;

  // A pending strobe or a locked sequence from the granted master freezes selection.
  assign hold = st_q.pend | ((st_q.gnt == MST_DMEM) ? m1_biu_lock_i : m0_biu_lock_i);

  riscv_biu_rr_arb u_rr_arb (
    .req_i  ({m1_biu_stb_i, m0_biu_stb_i}),
    .prio_i (st_q.prio),
    .hold_i (hold),
    .gnt_i  (st_q.gnt),
    .sel_o  (sel)
  );

  always_comb begin
    s_stb        = m0_biu_stb_i;
    s_biu_adri_o = m0_biu_adri_i;
    s_biu_size_o = m0_biu_size_i;
    s_biu_type_o = m0_biu_type_i;
    s_biu_prot_o = m0_biu_prot_i;
    s_biu_lock_o = m0_biu_lock_i;
    s_biu_we_o   = m0_biu_we_i;
    s_biu_d_o    = m0_biu_d_i;
    if (sel == MST_DMEM) begin
      s_stb        = m1_biu_stb_i;
      s_biu_adri_o = m1_biu_adri_i;
      s_biu_size_o = m1_biu_size_i;
      s_biu_type_o = m1_biu_type_i;
      s_biu_prot_o = m1_biu_prot_i;
      s_biu_lock_o = m1_biu_lock_i;
      s_biu_we_o   = m1_biu_we_i;
      s_biu_d_o    = m1_biu_d_i;
    end
  end

  assign s_biu_stb_o = s_stb;

  // Ownership moves only after the edge, so same-cycle d_ack/ack use the old owners.
  always_comb begin
    st_d      = st_q;
    st_d.gnt  = sel;
    st_d.pend = s_stb & ~s_biu_stb_ack_i & ~s_biu_err_i;
    if (s_biu_stb_ack_i) begin
      st_d.aowner = sel;
      st_d.prio   = other_mst(sel);
    end
    if (s_biu_d_ack_i) begin
      st_d.downer = st_q.aowner;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      st_q <= ARB_STATE_RST;
    end else begin
      st_q <= st_d;
    end
  end

  assign m0_biu_stb_ack_o = s_biu_stb_ack_i & (sel == MST_IMEM);
  assign m1_biu_stb_ack_o = s_biu_stb_ack_i & (sel == MST_DMEM);

  assign m0_biu_d_ack_o   = s_biu_d_ack_i & (st_q.aowner == MST_IMEM);
  assign m1_biu_d_ack_o   = s_biu_d_ack_i & (st_q.aowner == MST_DMEM);

  assign m0_biu_ack_o     = s_biu_ack_i & (st_q.downer == MST_IMEM);
  assign m1_biu_ack_o     = s_biu_ack_i & (st_q.downer == MST_DMEM);
  assign m0_biu_err_o     = s_biu_err_i & (st_q.downer == MST_IMEM);
  assign m1_biu_err_o     = s_biu_err_i & (st_q.downer == MST_DMEM);

  // Address/data returns are broadcast; only the per-master ack qualifies them.
  assign m0_biu_adro_o    = s_biu_adro_i;
  assign m1_biu_adro_o    = s_biu_adro_i;
  assign m0_biu_q_o       = s_biu_q_i;
  assign m1_biu_q_o       = s_biu_q_i;

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Bench for riscv_biu_arbiter: scenario tasks drive masters and the slave side;
// a negedge monitor pops expected {master, data} entries on every transfer ack.
module tb_riscv_biu_arbiter;

  localparam int XLEN = 64;
  localparam int PLEN = 64;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;

  logic            m0_biu_stb_i, m0_biu_stb_ack_o, m0_biu_d_ack_o;
  logic [PLEN-1:0] m0_biu_adri_i, m0_biu_adro_o;
  logic [2:0]      m0_biu_size_i, m0_biu_type_i, m0_biu_prot_i;
  logic            m0_biu_lock_i, m0_biu_we_i;
  logic [XLEN-1:0] m0_biu_d_i, m0_biu_q_o;
  logic            m0_biu_ack_o, m0_biu_err_o;

  logic            m1_biu_stb_i, m1_biu_stb_ack_o, m1_biu_d_ack_o;
  logic [PLEN-1:0] m1_biu_adri_i, m1_biu_adro_o;
  logic [2:0]      m1_biu_size_i, m1_biu_type_i, m1_biu_prot_i;
  logic            m1_biu_lock_i, m1_biu_we_i;
  logic [XLEN-1:0] m1_biu_d_i, m1_biu_q_o;
  logic            m1_biu_ack_o, m1_biu_err_o;

  logic            s_biu_stb_o, s_biu_stb_ack_i, s_biu_d_ack_i;
  logic [PLEN-1:0] s_biu_adri_o, s_biu_adro_i;
  logic [2:0]      s_biu_size_o, s_biu_type_o, s_biu_prot_o;
  logic            s_biu_lock_o, s_biu_we_o;
  logic [XLEN-1:0] s_biu_d_o, s_biu_q_i;
  logic            s_biu_ack_i, s_biu_err_i;

  int checks = 0;
  int errors = 0;
  logic [XLEN:0] exp_q[$];
  int dack_cnt = 0;
  logic pend_m = 1'b0;
  logic [PLEN-1:0] pend_adr = '0;

  riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_biu_stb_i(m0_biu_stb_i), .m0_biu_stb_ack_o(m0_biu_stb_ack_o), .m0_biu_d_ack_o(m0_biu_d_ack_o),
    .m0_biu_adri_i(m0_biu_adri_i), .m0_biu_adro_o(m0_biu_adro_o), .m0_biu_size_i(m0_biu_size_i),
    .m0_biu_type_i(m0_biu_type_i), .m0_biu_prot_i(m0_biu_prot_i), .m0_biu_lock_i(m0_biu_lock_i),
    .m0_biu_we_i(m0_biu_we_i), .m0_biu_d_i(m0_biu_d_i), .m0_biu_q_o(m0_biu_q_o),
    .m0_biu_ack_o(m0_biu_ack_o), .m0_biu_err_o(m0_biu_err_o),
    .m1_biu_stb_i(m1_biu_stb_i), .m1_biu_stb_ack_o(m1_biu_stb_ack_o), .m1_biu_d_ack_o(m1_biu_d_ack_o),
    .m1_biu_adri_i(m1_biu_adri_i), .m1_biu_adro_o(m1_biu_adro_o), .m1_biu_size_i(m1_biu_size_i),
    .m1_biu_type_i(m1_biu_type_i), .m1_biu_prot_i(m1_biu_prot_i), .m1_biu_lock_i(m1_biu_lock_i),
    .m1_biu_we_i(m1_biu_we_i), .m1_biu_d_i(m1_biu_d_i), .m1_biu_q_o(m1_biu_q_o),
    .m1_biu_ack_o(m1_biu_ack_o), .m1_biu_err_o(m1_biu_err_o),
    .s_biu_stb_o(s_biu_stb_o), .s_biu_stb_ack_i(s_biu_stb_ack_i), .s_biu_d_ack_i(s_biu_d_ack_i),
    .s_biu_adri_o(s_biu_adri_o), .s_biu_adro_i(s_biu_adro_i), .s_biu_size_o(s_biu_size_o),
    .s_biu_type_o(s_biu_type_o), .s_biu_prot_o(s_biu_prot_o), .s_biu_lock_o(s_biu_lock_o),
    .s_biu_we_o(s_biu_we_o), .s_biu_d_o(s_biu_d_o), .s_biu_q_i(s_biu_q_i),
    .s_biu_ack_i(s_biu_ack_i), .s_biu_err_i(s_biu_err_i)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: bench did not reach its end, got still running, expected done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m0(input logic stb, input logic [PLEN-1:0] adr, input logic we, input logic lock,
                          input logic [2:0] btype);
    m0_biu_stb_i  = stb;
    m0_biu_adri_i = adr;
    m0_biu_we_i   = we;
    m0_biu_lock_i = lock;
    m0_biu_type_i = btype;
    m0_biu_size_i = 3'b011;
    m0_biu_prot_i = 3'b100;
    m0_biu_d_i    = {32'h0000_0A0A, adr[31:0]};
  endtask

  task automatic drive_m1(input logic stb, input logic [PLEN-1:0] adr, input logic we, input logic lock);
    m1_biu_stb_i  = stb;
    m1_biu_adri_i = adr;
    m1_biu_we_i   = we;
    m1_biu_lock_i = lock;
    m1_biu_type_i = 3'b000;
    m1_biu_size_i = 3'b010;
    m1_biu_prot_i = 3'b001;
    m1_biu_d_i    = {32'h0000_0B0B, adr[31:0]};
  endtask

  task automatic drive_s(input logic sa, input logic da, input logic ak, input logic er,
                         input logic [XLEN-1:0] qv, input logic [PLEN-1:0] adro);
    s_biu_stb_ack_i = sa;
    s_biu_d_ack_i   = da;
    s_biu_ack_i     = ak;
    s_biu_err_i     = er;
    s_biu_q_i       = qv;
    s_biu_adro_i    = adro;
  endtask

  task automatic apply_reset();
    HRESET = 1'b1;
    drive_m0(1'b0, '0, 1'b0, 1'b0, 3'b000);
    drive_m1(1'b0, '0, 1'b0, 1'b0);
    drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    step();
    HRESET = 1'b0;
    step();
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge HCLK) begin
    if (HRESET) begin
      dack_cnt = 0;
      pend_m   = 1'b0;
    end else begin
      if (pend_m) begin
        checks++;
        if (s_biu_adri_o !== pend_adr) begin
          errors++;
          $display("FAIL sel_stable_while_pend: s_adri_o got %h expected %h", s_biu_adri_o, pend_adr);
        end
      end
      if (s_biu_ack_i || s_biu_err_i) begin
        checks++;
        if (dack_cnt == 0) begin
          errors++;
          $display("FAIL ack_without_dack: outstanding d_acks got 0 expected >0");
        end else begin
          dack_cnt--;
        end
      end
      if (s_biu_d_ack_i) dack_cnt++;
      pend_m   = s_biu_stb_o & ~s_biu_stb_ack_i & ~s_biu_err_i;
      pend_adr = s_biu_adri_o;

      if (m0_biu_ack_o || m1_biu_ack_o) begin
        logic [XLEN:0] ent;
        checks++;
        if (m0_biu_ack_o && m1_biu_ack_o) begin
          errors++;
          $display("FAIL ack_both: m0_ack=%b m1_ack=%b expected one-hot", m0_biu_ack_o, m1_biu_ack_o);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: m0_ack=%b m1_ack=%b expected no ack", m0_biu_ack_o, m1_biu_ack_o);
        end else begin
          ent = exp_q.pop_front();
          if (m1_biu_ack_o !== ent[XLEN] ||
              (ent[XLEN] ? m1_biu_q_o : m0_biu_q_o) !== ent[XLEN-1:0]) begin
            errors++;
            $display("FAIL ack_route: got m1_ack=%b q=%h expected master %0d q=%h",
                     m1_biu_ack_o, (ent[XLEN] ? m1_biu_q_o : m0_biu_q_o), ent[XLEN], ent[XLEN-1:0]);
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (s_biu_stb_o !== 1'b0 || {m0_biu_stb_ack_o, m0_biu_d_ack_o, m0_biu_ack_o, m0_biu_err_o,
        m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: s_stb=%b m0/m1 acks=%b%b%b%b_%b%b%b%b expected all 0", s_biu_stb_o,
               m0_biu_stb_ack_o, m0_biu_d_ack_o, m0_biu_ack_o, m0_biu_err_o,
               m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o);
    end
  endtask

  task automatic test_single_read();
    drive_m0(1'b1, 64'h1000, 1'b0, 1'b0, 3'b000);
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (s_biu_stb_o !== 1'b1 || s_biu_adri_o !== 64'h1000 || m0_biu_stb_ack_o !== 1'b1 || m1_biu_stb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL single_stb: s_stb=%b adr=%h m0_sa=%b m1_sa=%b expected 1 1000 1 0",
               s_biu_stb_o, s_biu_adri_o, m0_biu_stb_ack_o, m1_biu_stb_ack_o);
    end
    exp_q.push_back({1'b0, 64'h0000_0000_DEAD_BEEF});
    step();
    drive_m0(1'b0, 64'h1000, 1'b0, 1'b0, 3'b000);
    drive_s(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m0_biu_d_ack_o !== 1'b1 || m1_biu_d_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL single_dack: m0=%b m1=%b expected 1 0", m0_biu_d_ack_o, m1_biu_d_ack_o);
    end
    step();
    drive_s(1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'h1000);
    #1;
    checks++;
    if ({m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o} !== 4'h0 || m0_biu_adro_o !== 64'h1000) begin
      errors++;
      $display("FAIL single_m1_quiet: m1 acks=%b%b%b%b m0_adro=%h expected 0000 1000",
               m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o, m0_biu_adro_o);
    end
    step();
    drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_priority_alternation();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      drive_m0(1'b1, 64'h100 + 64'(r * 16), 1'b0, 1'b0, 3'b000);
      drive_m1(1'b1, 64'h200 + 64'(r * 16), 1'b0, 1'b0);
      drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      checks++;
      if (m1_biu_stb_ack_o !== 1'b1 || m0_biu_stb_ack_o !== 1'b0 || s_biu_adri_o !== 64'h200 + 64'(r * 16)) begin
        errors++;
        $display("FAIL prio_m1_first r%0d: m1_sa=%b m0_sa=%b adr=%h expected 1 0 %h", r,
                 m1_biu_stb_ack_o, m0_biu_stb_ack_o, s_biu_adri_o, 64'h200 + 64'(r * 16));
      end
      exp_q.push_back({1'b1, 64'hA0 + 64'(r)});
      step();
      drive_m1(1'b0, '0, 1'b0, 1'b0);
      drive_s(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      #1;
      checks++;
      if (m1_biu_d_ack_o !== 1'b1 || m0_biu_d_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL prio_m1_dack r%0d: m1=%b m0=%b expected 1 0", r, m1_biu_d_ack_o, m0_biu_d_ack_o);
      end
      step();
      drive_s(1'b0, 1'b0, 1'b1, 1'b0, 64'hA0 + 64'(r), '0);
      step();
      drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      checks++;
      if (m0_biu_stb_ack_o !== 1'b1 || m1_biu_stb_ack_o !== 1'b0 || s_biu_adri_o !== 64'h100 + 64'(r * 16)) begin
        errors++;
        $display("FAIL prio_m0_next r%0d: m0_sa=%b m1_sa=%b adr=%h expected 1 0 %h", r,
                 m0_biu_stb_ack_o, m1_biu_stb_ack_o, s_biu_adri_o, 64'h100 + 64'(r * 16));
      end
      exp_q.push_back({1'b0, 64'hB0 + 64'(r)});
      step();
      drive_m0(1'b0, '0, 1'b0, 1'b0, 3'b000);
      drive_s(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      step();
      drive_s(1'b0, 1'b0, 1'b1, 1'b0, 64'hB0 + 64'(r), '0);
      step();
      drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_stall();
    drive_m0(1'b1, 64'h4000, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drive_m1(1'b1, 64'h5000, 1'b0, 1'b0);
      #1;
      checks++;
      if (s_biu_stb_o !== 1'b1 || s_biu_adri_o !== 64'h4000 || m1_biu_stb_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c%0d: s_stb=%b adr=%h m1_sa=%b expected 1 4000 0", i,
                 s_biu_stb_o, s_biu_adri_o, m1_biu_stb_ack_o);
      end
      step();
    end
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m0_biu_stb_ack_o !== 1'b1 || m1_biu_stb_ack_o !== 1'b0 || s_biu_adri_o !== 64'h4000) begin
      errors++;
      $display("FAIL stall_accept: m0_sa=%b m1_sa=%b adr=%h expected 1 0 4000",
               m0_biu_stb_ack_o, m1_biu_stb_ack_o, s_biu_adri_o);
    end
    exp_q.push_back({1'b0, 64'hC0});
    step();
    drive_m0(1'b0, '0, 1'b0, 1'b0, 3'b000);
    drive_s(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    drive_s(1'b0, 1'b0, 1'b1, 1'b0, 64'hC0, '0);
    step();
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m1_biu_stb_ack_o !== 1'b1 || m0_biu_stb_ack_o !== 1'b0 || s_biu_adri_o !== 64'h5000) begin
      errors++;
      $display("FAIL stall_m1_next: m1_sa=%b m0_sa=%b adr=%h expected 1 0 5000",
               m1_biu_stb_ack_o, m0_biu_stb_ack_o, s_biu_adri_o);
    end
    exp_q.push_back({1'b1, 64'hC1});
    step();
    drive_m1(1'b0, '0, 1'b0, 1'b0);
    drive_s(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    drive_s(1'b0, 1'b0, 1'b1, 1'b0, 64'hC1, '0);
    step();
    drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    drive_m1(1'b1, 64'h2000, 1'b1, 1'b0);
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m1_biu_stb_ack_o !== 1'b1 || s_biu_we_o !== 1'b1 || s_biu_d_o !== 64'h0000_0B0B_0000_2000) begin
      errors++;
      $display("FAIL b2b_m1_write: m1_sa=%b we=%b d=%h expected 1 1 00000b0b00002000",
               m1_biu_stb_ack_o, s_biu_we_o, s_biu_d_o);
    end
    exp_q.push_back({1'b1, 64'h0});
    step();
    drive_m1(1'b0, '0, 1'b0, 1'b0);
    drive_m0(1'b1, 64'h3000, 1'b0, 1'b0, 3'b000);
    drive_s(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m0_biu_stb_ack_o !== 1'b1 || m1_biu_d_ack_o !== 1'b1 || m0_biu_d_ack_o !== 1'b0 || s_biu_we_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overlap: m0_sa=%b m1_da=%b m0_da=%b we=%b expected 1 1 0 0",
               m0_biu_stb_ack_o, m1_biu_d_ack_o, m0_biu_d_ack_o, s_biu_we_o);
    end
    exp_q.push_back({1'b0, 64'hCAFE});
    step();
    drive_m0(1'b0, '0, 1'b0, 1'b0, 3'b000);
    drive_s(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, '0);
    #1;
    checks++;
    if (m0_biu_d_ack_o !== 1'b1 || m1_biu_d_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_m0_dack: m0=%b m1=%b expected 1 0", m0_biu_d_ack_o, m1_biu_d_ack_o);
    end
    step();
    drive_s(1'b0, 1'b0, 1'b1, 1'b0, 64'hCAFE, '0);
    step();
    drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_error();
    drive_m0(1'b1, 64'h6000, 1'b0, 1'b0, 3'b011);
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m0_biu_stb_ack_o !== 1'b1 || s_biu_type_o !== 3'b011 || s_biu_prot_o !== 3'b100) begin
      errors++;
      $display("FAIL err_accept: m0_sa=%b type=%b prot=%b expected 1 011 100",
               m0_biu_stb_ack_o, s_biu_type_o, s_biu_prot_o);
    end
    exp_q.push_back({1'b0, 64'h11});
    step();
    drive_m0(1'b1, 64'h6020, 1'b0, 1'b0, 3'b000);
    drive_s(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    drive_m1(1'b1, 64'h7000, 1'b0, 1'b0);
    drive_s(1'b0, 1'b1, 1'b1, 1'b0, 64'h11, '0);
    #1;
    checks++;
    if (m0_biu_d_ack_o !== 1'b1 || s_biu_adri_o !== 64'h6020) begin
      errors++;
      $display("FAIL err_beat2: m0_da=%b adr=%h expected 1 6020", m0_biu_d_ack_o, s_biu_adri_o);
    end
    step();
    drive_s(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    #1;
    checks++;
    if (m0_biu_err_o !== 1'b1 || m1_biu_err_o !== 1'b0 || m0_biu_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL err_route: m0_err=%b m1_err=%b m0_ack=%b expected 1 0 0",
               m0_biu_err_o, m1_biu_err_o, m0_biu_ack_o);
    end
    step();
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m0_biu_err_o !== 1'b0 || m1_biu_stb_ack_o !== 1'b1 || m0_biu_stb_ack_o !== 1'b0 || s_biu_adri_o !== 64'h7000) begin
      errors++;
      $display("FAIL err_pend_cleared: m0_err=%b m1_sa=%b m0_sa=%b adr=%h expected 0 1 0 7000",
               m0_biu_err_o, m1_biu_stb_ack_o, m0_biu_stb_ack_o, s_biu_adri_o);
    end
    exp_q.push_back({1'b1, 64'h77});
    step();
    drive_m0(1'b0, '0, 1'b0, 1'b0, 3'b000);
    drive_m1(1'b0, '0, 1'b0, 1'b0);
    drive_s(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    drive_s(1'b0, 1'b0, 1'b1, 1'b0, 64'h77, '0);
    step();
    drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_lock_and_reset();
    apply_reset();
    drive_m0(1'b1, 64'h8000, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      drive_m1(1'b1, 64'h9000 + 64'(i * 8), 1'b0, 1'b1);
      drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      checks++;
      if (m1_biu_stb_ack_o !== 1'b1 || m0_biu_stb_ack_o !== 1'b0 || s_biu_lock_o !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold s%0d: m1_sa=%b m0_sa=%b lock=%b expected 1 0 1", i,
                 m1_biu_stb_ack_o, m0_biu_stb_ack_o, s_biu_lock_o);
      end
      step();
    end
    drive_m1(1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++;
    if (m0_biu_stb_ack_o !== 1'b1 || s_biu_adri_o !== 64'h8000) begin
      errors++;
      $display("FAIL lock_release: m0_sa=%b adr=%h expected 1 8000", m0_biu_stb_ack_o, s_biu_adri_o);
    end
    step();
    drive_m0(1'b0, '0, 1'b0, 1'b0, 3'b000);
    HRESET = 1'b1;
    drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if ({m0_biu_stb_ack_o, m0_biu_d_ack_o, m0_biu_ack_o, m0_biu_err_o,
         m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_acks: m0/m1 acks=%b%b%b%b_%b%b%b%b expected all 0",
               m0_biu_stb_ack_o, m0_biu_d_ack_o, m0_biu_ack_o, m0_biu_err_o,
               m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o);
    end
    step();
    step();
    HRESET = 1'b0;
    // gnt=0 after reset: m0 lock holds selection on idle m0 even with m1 requesting
    drive_m0(1'b0, 64'h8100, 1'b0, 1'b1, 3'b000);
    drive_m1(1'b1, 64'h9100, 1'b0, 1'b0);
    #1;
    checks++;
    if (s_biu_stb_o !== 1'b0 || s_biu_adri_o !== 64'h8100) begin
      errors++;
      $display("FAIL reset_gnt: s_stb=%b adr=%h expected 0 8100", s_biu_stb_o, s_biu_adri_o);
    end
    step();
    drive_m0(1'b1, 64'h8100, 1'b0, 1'b0, 3'b000);
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (m1_biu_stb_ack_o !== 1'b1 || m0_biu_stb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_prio: m1_sa=%b m0_sa=%b expected 1 0", m1_biu_stb_ack_o, m0_biu_stb_ack_o);
    end
    step();
    drive_m0(1'b0, '0, 1'b0, 1'b0, 3'b000);
    drive_m1(1'b0, '0, 1'b0, 1'b0);
    drive_s(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_priority_alternation();
    test_stall();
    test_back_to_back();
    test_error();
    test_lock_and_reset();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
